// File: rtl/udp_oe_pkg.sv
// Shared types and constants for the UDP offload engine channel schedulers.
// Holds the arbiter state encoding, channel-ID sizing and the round-robin wrap helper.
package udp_oe_pkg;

   localparam int ARB_CHAN_ID_W = 3;
   localparam int ARB_MAX_CHAN  = 8;

   typedef enum logic [1:0] {ARB_IDLE, ARB_XFER, ARB_ABORT} arb_state_e;

   // Next channel after c, wrapping modulo n.
   function automatic logic [ARB_CHAN_ID_W-1:0] chan_next(input logic [ARB_CHAN_ID_W-1:0] c,
                                                          input int n);
      int nx;
      nx = (int'(c) + 1) % n;
      return nx[ARB_CHAN_ID_W-1:0];
   endfunction

endpackage

// File: rtl/udp_oe_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr, wrapping; zero latency.
// No backpressure of its own; grant_oh is all-zero when no request is pending.
module udp_oe_rr_pick
   import udp_oe_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]               req,
   input  logic [ARB_CHAN_ID_W-1:0]   ptr,
   output logic [N-1:0]               grant_oh,
   output logic [ARB_CHAN_ID_W-1:0]   idx,
   output logic                       any_req
);

   always_comb begin
      logic found;
      int   c;
      found    = 1'b0;
      c        = 0;
      grant_oh = '0;
      idx      = '0;
      any_req  = |req;
      for (int k = 0; k < N; k++) begin
         c = (int'(ptr) + k) % N;
         if (!found && req[c]) begin
            found       = 1'b1;
            idx         = c[ARB_CHAN_ID_W-1:0];
            grant_oh[c] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/udp_oe_tx_chan_arb.sv
// Packet-granular RR scheduler onto the shared UOE TX path; 1-cycle grant bubble, then a comb mux.
// Owner's in_ready follows out_ready; others held off. Optional counters: UDP_OE_TX_ARB_STATS_EN.
module udp_oe_tx_chan_arb
   import udp_oe_pkg::*;
#(
   parameter int NUM_CHAN = 4,
   parameter int DATA_W   = 64,
   parameter int EMPTY_W  = 3
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         arb_en,
   input  logic [NUM_CHAN-1:0]          chan_tx_rst,
   input  logic [NUM_CHAN-1:0]          in_valid,
   output logic [NUM_CHAN-1:0]          in_ready,
   input  logic [NUM_CHAN*DATA_W-1:0]   in_data,
   input  logic [NUM_CHAN-1:0]          in_last,
   input  logic [NUM_CHAN*EMPTY_W-1:0]  in_empty,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_W-1:0]            out_data,
   output logic                         out_last,
   output logic [EMPTY_W-1:0]           out_empty,
   output logic                         out_error,
   output logic [ARB_CHAN_ID_W-1:0]     out_chan,
   output logic [NUM_CHAN-1:0]          grant,
   output logic                         busy
`ifdef UDP_OE_TX_ARB_STATS_EN
   ,
   input  logic                         stats_clr,
   output logic [NUM_CHAN*32-1:0]       pkt_cnt,
   output logic [NUM_CHAN*16-1:0]       abort_cnt
`endif
);

   arb_state_e                 state;
   logic [ARB_CHAN_ID_W-1:0]   sel;
   logic [ARB_CHAN_ID_W-1:0]   rr_ptr;
   logic [NUM_CHAN-1:0]        req;
   logic [NUM_CHAN-1:0]        pick_oh;
   logic [ARB_CHAN_ID_W-1:0]   pick_idx;
   logic                       pick_any;
   logic                       cur_valid;
   logic                       cur_last;
   logic                       cur_rst;
   logic [DATA_W-1:0]          cur_data;
   logic [EMPTY_W-1:0]         cur_empty;
   logic                       beat_acc;

   assign req      = in_valid & ~chan_tx_rst;
   assign out_chan = sel;
   assign busy     = (state != ARB_IDLE);
   assign beat_acc = out_valid & out_ready;

   udp_oe_rr_pick #(.N(NUM_CHAN)) u_pick (
      .req      (req),
      .ptr      (rr_ptr),
      .grant_oh (pick_oh),
      .idx      (pick_idx),
      .any_req  (pick_any)
   );

   always_comb begin
      cur_valid = 1'b0;
      cur_last  = 1'b0;
      cur_rst   = 1'b0;
      cur_data  = '0;
      cur_empty = '0;
      for (int i = 0; i < NUM_CHAN; i++) begin
         if (sel == ARB_CHAN_ID_W'(i)) begin
            cur_valid = in_valid[i];
            cur_last  = in_last[i];
            cur_rst   = chan_tx_rst[i];
            cur_data  = in_data[i*DATA_W +: DATA_W];
            cur_empty = in_empty[i*EMPTY_W +: EMPTY_W];
         end
      end
   end

   always_comb begin
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_error = 1'b0;
      out_data  = '0;
      out_empty = '0;
      in_ready  = '0;
      case (state)
         ARB_XFER: begin
            out_valid = cur_valid;
            out_last  = cur_last;
            out_data  = cur_data;
            out_empty = cur_empty;
            for (int i = 0; i < NUM_CHAN; i++)
               if (sel == ARB_CHAN_ID_W'(i)) in_ready[i] = out_ready;
         end
         // Synthetic terminating beat so downstream can drop the partial packet.
         ARB_ABORT: begin
            out_valid = 1'b1;
            out_last  = 1'b1;
            out_error = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ARB_IDLE;
         rr_ptr <= '0;
         sel    <= '0;
         grant  <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (arb_en && pick_any) begin
                  grant <= pick_oh;
                  sel   <= pick_idx;
                  state <= ARB_XFER;
               end
            end
            ARB_XFER: begin
               // A completed last beat wins over a same-cycle channel reset.
               if (beat_acc && cur_last) begin
                  rr_ptr <= chan_next(sel, NUM_CHAN);
                  grant  <= '0;
                  state  <= ARB_IDLE;
               end else if (cur_rst) begin
                  state <= ARB_ABORT;
               end
            end
            ARB_ABORT: begin
               if (out_ready) begin
                  rr_ptr <= chan_next(sel, NUM_CHAN);
                  grant  <= '0;
                  state  <= ARB_IDLE;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

`ifdef UDP_OE_TX_ARB_STATS_EN
   logic [31:0] pkt_q   [NUM_CHAN];
   logic [15:0] abort_q [NUM_CHAN];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CHAN; i++) begin
            pkt_q[i]   <= '0;
            abort_q[i] <= '0;
         end
      end else if (stats_clr) begin
         for (int i = 0; i < NUM_CHAN; i++) begin
            pkt_q[i]   <= '0;
            abort_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CHAN; i++) begin
            if (sel == ARB_CHAN_ID_W'(i)) begin
               if (state == ARB_XFER && beat_acc && cur_last)
                  pkt_q[i] <= pkt_q[i] + 32'd1;
               if (state == ARB_ABORT && out_ready && abort_q[i] != 16'hFFFF)
                  abort_q[i] <= abort_q[i] + 16'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CHAN; g++) begin : g_stats
      assign pkt_cnt[g*32 +: 32]   = pkt_q[g];
      assign abort_cnt[g*16 +: 16] = abort_q[g];
   end
`endif

endmodule

// File: tb/tb_udp_oe_tx_chan_arb.sv
// Directed bench for udp_oe_tx_chan_arb: queue-fed channel sources, output beat log, hand-derived checks.
// Stats checks build only with UDP_OE_TX_ARB_STATS_EN defined.
module tb_udp_oe_tx_chan_arb;

   localparam int NC = 4;
   localparam int DW = 64;
   localparam int EW = 3;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic                arb_en = 1'b0;
   logic [NC-1:0]       chan_tx_rst = '0;
   logic [NC-1:0]       in_valid = '0;
   logic [NC-1:0]       in_ready;
   logic [NC*DW-1:0]    in_data = '0;
   logic [NC-1:0]       in_last = '0;
   logic [NC*EW-1:0]    in_empty = '0;
   logic                out_valid;
   logic                out_ready = 1'b1;
   logic [DW-1:0]       out_data;
   logic                out_last;
   logic [EW-1:0]       out_empty;
   logic                out_error;
   logic [2:0]          out_chan;
   logic [NC-1:0]       grant;
   logic                busy;
`ifdef UDP_OE_TX_ARB_STATS_EN
   logic                stats_clr = 1'b0;
   logic [NC*32-1:0]    pkt_cnt;
   logic [NC*16-1:0]    abort_cnt;
`endif

   udp_oe_tx_chan_arb #(.NUM_CHAN(NC), .DATA_W(DW), .EMPTY_W(EW)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .arb_en      (arb_en),
      .chan_tx_rst (chan_tx_rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .in_empty    (in_empty),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .out_empty   (out_empty),
      .out_error   (out_error),
      .out_chan    (out_chan),
      .grant       (grant),
      .busy        (busy)
`ifdef UDP_OE_TX_ARB_STATS_EN
      ,
      .stats_clr   (stats_clr),
      .pkt_cnt     (pkt_cnt),
      .abort_cnt   (abort_cnt)
`endif
   );

   typedef struct {
      logic [63:0] data;
      logic        last;
      logic [2:0]  empty;
   } beat_t;

   typedef struct {
      logic [2:0]  chan;
      logic [63:0] data;
      logic        last;
      logic [2:0]  empty;
      logic        err;
      int          cyc;
   } obs_t;

   beat_t         src_q [NC][$];
   obs_t          out_log[$];
   obs_t          mon_o;
   logic [NC-1:0] fired = '0;
   int            cyc = 0;
   bit            rdy_tog = 1'b0;
   int            log_base = 0;
   int            n_cmp = 0;
   int            n_err = 0;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mkd(input int ch, input int pkt, input int b);
      return {16'hCAFE, 8'(ch), 8'(pkt), 16'h0000, 16'(b)};
   endfunction

   function automatic obs_t lg(input int k);
      return out_log[log_base + k];
   endfunction

   function automatic int n_log();
      return out_log.size() - log_base;
   endfunction

   // Sources: pop what was accepted at the last edge, then present the next head.
   always @(posedge clk) begin
      cyc++;
      #1;
      for (int i = 0; i < NC; i++) begin
         if (fired[i] && src_q[i].size() > 0) src_q[i].delete(0);
         if (src_q[i].size() > 0) begin
            in_valid[i]            = 1'b1;
            in_data[i*DW +: DW]    = src_q[i][0].data;
            in_last[i]             = src_q[i][0].last;
            in_empty[i*EW +: EW]   = src_q[i][0].empty;
         end else begin
            in_valid[i]            = 1'b0;
            in_data[i*DW +: DW]    = '0;
            in_last[i]             = 1'b0;
            in_empty[i*EW +: EW]   = '0;
         end
      end
      out_ready = rdy_tog ? ~out_ready : 1'b1;
   end

   always @(negedge clk) begin
      fired = in_valid & in_ready;
      if (reset_n && out_valid && out_ready) begin
         mon_o.chan  = out_chan;
         mon_o.data  = out_data;
         mon_o.last  = out_last;
         mon_o.empty = out_empty;
         mon_o.err   = out_error;
         mon_o.cyc   = cyc;
         out_log.push_back(mon_o);
      end
   end

   task automatic add_pkt(input int ch, input int pkt, input int n, input int emp);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b.data  = mkd(ch, pkt, k);
         b.last  = (k == n - 1);
         b.empty = (k == n - 1) ? 3'(emp) : 3'd0;
         src_q[ch].push_back(b);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_log(input int n, input int max, input string tag);
      int k = 0;
      while (n_log() < n && k < max) begin
         @(posedge clk);
         #2;
         k++;
      end
      chk(tag, 64'(n_log() >= n), 64'd1);
   endtask

   task automatic do_reset(input string tag);
      reset_n     = 1'b0;
      arb_en      = 1'b0;
      chan_tx_rst = '0;
      rdy_tog     = 1'b0;
      #1;
      chk({tag, "_grant"},   64'(grant),     64'd0);
      chk({tag, "_busy"},    64'(busy),      64'd0);
      chk({tag, "_ovld"},    64'(out_valid), 64'd0);
      chk({tag, "_olast"},   64'(out_last),  64'd0);
      chk({tag, "_oerr"},    64'(out_error), 64'd0);
      chk({tag, "_ochan"},   64'(out_chan),  64'd0);
      chk({tag, "_inrdy"},   64'(in_ready),  64'd0);
      @(negedge clk);
      for (int i = 0; i < NC; i++) src_q[i].delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n  = 1'b1;
      log_base = out_log.size();
      @(posedge clk);
      #2;
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Two channels, one 3-beat packet each.
      do_reset("rst1");
      add_pkt(0, 0, 3, 0);
      add_pkt(2, 0, 3, 2);
      arb_en = 1'b1;
      wait_log(6, 50, "t1_drain");
      idle(3);
      chk("t1_beats", 64'(n_log()), 64'd6);
      for (int k = 0; k < 6; k++) begin
         int ch;
         ch = (k < 3) ? 0 : 2;
         chk($sformatf("t1_chan%0d", k), 64'(lg(k).chan), 64'(ch));
         chk($sformatf("t1_data%0d", k), lg(k).data, mkd(ch, 0, k % 3));
         chk($sformatf("t1_last%0d", k), 64'(lg(k).last), 64'(k % 3 == 2));
      end
      chk("t1_empty_last", 64'(lg(5).empty), 64'd2);
      chk("t1_bubble", 64'(lg(3).cyc - lg(2).cyc), 64'd2);
      chk("t1_rr_ptr", 64'(dut.rr_ptr), 64'd3);
      chk("t1_grant_idle", 64'(grant), 64'd0);
      chk("t1_busy_idle", 64'(busy), 64'd0);

      // All four channels, two back-to-back 2-beat packets each.
      do_reset("rst2");
      for (int p = 0; p < 2; p++)
         for (int ch = 0; ch < NC; ch++) add_pkt(ch, p, 2, ch);
      arb_en = 1'b1;
      wait_log(16, 200, "t2_drain");
      idle(2);
      chk("t2_beats", 64'(n_log()), 64'd16);
      for (int k = 0; k < 16; k++) begin
         int ch;
         ch = (k / 2) % 4;
         chk($sformatf("t2_chan%0d", k), 64'(lg(k).chan), 64'(ch));
         chk($sformatf("t2_data%0d", k), lg(k).data, mkd(ch, k / 8, k % 2));
         chk($sformatf("t2_last%0d", k), 64'(lg(k).last), 64'(k % 2));
      end

      // ch1 reset after its second beat of five: third beat still delivered, then abort.
      do_reset("rst3");
      add_pkt(1, 0, 5, 0);
      arb_en = 1'b1;
      wait_log(2, 20, "t3_two_beats");
      chan_tx_rst[1] = 1'b1;
      wait_log(4, 20, "t3_abort_seen");
      idle(10);
      chk("t3_beats", 64'(n_log()), 64'd4);
      chk("t3_b2_data", lg(2).data, mkd(1, 0, 2));
      chk("t3_b2_err", 64'(lg(2).err), 64'd0);
      chk("t3_ab_data", lg(3).data, 64'd0);
      chk("t3_ab_last", 64'(lg(3).last), 64'd1);
      chk("t3_ab_err", 64'(lg(3).err), 64'd1);
      chk("t3_ab_empty", 64'(lg(3).empty), 64'd0);
      chk("t3_ab_chan", 64'(lg(3).chan), 64'd1);
      chk("t3_no_regrant", 64'(grant), 64'd0);
      chk("t3_busy", 64'(busy), 64'd0);
      chk("t3_rr_ptr", 64'(dut.rr_ptr), 64'd2);

      // ch3 4-beat packet with out_ready toggling every cycle.
      do_reset("rst4");
      add_pkt(3, 0, 4, 5);
      rdy_tog = 1'b1;
      arb_en  = 1'b1;
      wait_log(4, 50, "t4_drain");
      idle(6);
      rdy_tog = 1'b0;
      chk("t4_beats", 64'(n_log()), 64'd4);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t4_data%0d", k), lg(k).data, mkd(3, 0, k));
         chk($sformatf("t4_last%0d", k), 64'(lg(k).last), 64'(k == 3));
      end
      for (int k = 0; k < 3; k++)
         chk($sformatf("t4_gap%0d", k), 64'(lg(k + 1).cyc - lg(k).cyc), 64'd2);
      chk("t4_empty_last", 64'(lg(3).empty), 64'd5);

      // arb_en dropped during beat 1 of a ch0 packet.
      do_reset("rst5");
      add_pkt(0, 0, 3, 0);
      add_pkt(0, 1, 3, 0);
      add_pkt(1, 0, 2, 0);
      arb_en = 1'b1;
      wait_log(1, 20, "t5_first");
      arb_en = 1'b0;
      wait_log(3, 20, "t5_pkt_done");
      idle(8);
      chk("t5_held_beats", 64'(n_log()), 64'd3);
      chk("t5_held_last", 64'(lg(2).last), 64'd1);
      chk("t5_held_grant", 64'(grant), 64'd0);
      chk("t5_held_busy", 64'(busy), 64'd0);
      chk("t5_rr_ptr", 64'(dut.rr_ptr), 64'd1);
      arb_en = 1'b1;
      wait_log(8, 60, "t5_resume");
      chk("t5_next_chan", 64'(lg(3).chan), 64'd1);
      chk("t5_then_chan", 64'(lg(5).chan), 64'd0);
      chk("t5_final_data", lg(7).data, mkd(0, 1, 2));

`ifdef UDP_OE_TX_ARB_STATS_EN
      do_reset("rst6");
      for (int p = 0; p < 5; p++) add_pkt(2, p, 1, 0);
      arb_en = 1'b1;
      wait_log(5, 60, "t6_pkts");
      add_pkt(2, 5, 3, 0);
      wait_log(6, 20, "t6_abort_start");
      chan_tx_rst[2] = 1'b1;
      wait_log(8, 20, "t6_abort_seen");
      idle(4);
      chk("t6_pkt_cnt2", 64'(pkt_cnt[2*32 +: 32]), 64'd5);
      chk("t6_abort_cnt2", 64'(abort_cnt[2*16 +: 16]), 64'd1);
      chk("t6_pkt_cnt0", 64'(pkt_cnt[0 +: 32]), 64'd0);
      chk("t6_abort_cnt0", 64'(abort_cnt[0 +: 16]), 64'd0);
      stats_clr = 1'b1;
      idle(1);
      stats_clr = 1'b0;
      chk("t6_pkt_clr", 64'(|pkt_cnt), 64'd0);
      chk("t6_abort_clr", 64'(|abort_cnt), 64'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
